// File: rtl/pipelined_adder_32_if.sv
// Operand/result bundle for the four-stage pipelined adder.
// The master side is the producer/consumer around the adder; the slave side is the adder itself.
interface pipelined_adder_32_if #(
  parameter int WIDTH = 32
);

  logic             en;
  logic             inValid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic [WIDTH-1:0] sum;
  logic             cOut;
  logic             ovf;
  logic             outValid;

  modport master (
    output en,
    output inValid,
    output a,
    output b,
    output cIn,
    input  sum,
    input  cOut,
    input  ovf,
    input  outValid
  );

  modport slave (
    input  en,
    input  inValid,
    input  a,
    input  b,
    input  cIn,
    output sum,
    output cOut,
    output ovf,
    output outValid
  );

endinterface

// File: rtl/pipelined_adder_32.sv
// Pipelined WIDTH-bit adder: one SLICE-bit ripple-carry slice per stage, carry registered
// between stages. Operands are skewed on the way in so each slice meets its carry, and the
// finished low sum bytes are carried forward alongside so the full result leaves aligned.
// Latency is NUM_SLICES cycles, throughput one operation per cycle, en=0 freezes everything.
// The interface WIDTH must match this module's WIDTH.
module pipelined_adder_32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  pipelined_adder_32_if.slave  bus
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int LAST       = NUM_SLICES - 1;

  // Stage k sees the operand bits from its own slice upward, a carry-in, a valid bit and
  // the sum bytes already produced below it. Stage 0 sees the ports directly; every later
  // stage sees registers loaded from the stage before it.
  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int HI = LO + SLICE - 1;

    logic [WIDTH-1:LO] op_a;
    logic [WIDTH-1:LO] op_b;
    logic              c_in;
    logic              v_in;
    logic [SLICE-1:0]  byte_sum;
    logic              c_out;
    logic [HI:0]       sum_full;

    assign {c_out, byte_sum} = {1'b0, op_a[HI:LO]} + {1'b0, op_b[HI:LO]} + {{SLICE{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign op_a     = bus.a;
      assign op_b     = bus.b;
      assign c_in     = bus.cIn;
      assign v_in     = bus.inValid;
      assign sum_full = byte_sum;
    end else begin : g_src
      logic [LO-1:0] lo_sum_q;

      assign sum_full = {byte_sum, lo_sum_q};

      // Advance the skewed operands, carry, valid and low sum bytes from the previous stage.
      always_ff @(posedge clk) begin
        if (!rstN) begin
          op_a     <= '0;
          op_b     <= '0;
          c_in     <= 1'b0;
          v_in     <= 1'b0;
          lo_sum_q <= '0;
        end else if (bus.en) begin
          op_a     <= g_stage[k-1].op_a[WIDTH-1:LO];
          op_b     <= g_stage[k-1].op_b[WIDTH-1:LO];
          c_in     <= g_stage[k-1].c_out;
          v_in     <= g_stage[k-1].v_in;
          lo_sum_q <= g_stage[k-1].sum_full;
        end
      end
    end
  end

  // Signed overflow: both operands share a sign and the result's sign differs from it.
  logic a_msb;
  logic b_msb;
  logic s_msb;
  logic ovf_next;

  assign a_msb    = g_stage[LAST].op_a[WIDTH-1];
  assign b_msb    = g_stage[LAST].op_b[WIDTH-1];
  assign s_msb    = g_stage[LAST].sum_full[WIDTH-1];
  assign ovf_next = (a_msb == b_msb) && (s_msb != a_msb);

  // Register the completed result of the top slice as the visible output.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      bus.sum      <= '0;
      bus.cOut     <= 1'b0;
      bus.ovf      <= 1'b0;
      bus.outValid <= 1'b0;
    end else if (bus.en) begin
      bus.sum      <= g_stage[LAST].sum_full;
      bus.cOut     <= g_stage[LAST].c_out;
      bus.ovf      <= ovf_next;
      bus.outValid <= g_stage[LAST].v_in;
    end
  end

endmodule

// File: doc/pipelined_adder_32.md
Name: pipelined_adder_32

Overview:
- Four-stage pipelined 32-bit adder built from one 8-bit ripple-carry slice per stage, with the carry registered between stages.
- Sits in the datapath above the 8-bit ripple-carry slice. It feeds each slice its skewed operand bytes and carry-in, then consumes each slice's sum byte and carry-out.
- Accepts one operand pair per cycle. Produces a full 32-bit sum, carry-out and signed-overflow flag NUM_SLICES cycles later.
- A global enable lets downstream logic stall the pipeline.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of SLICE.
- SLICE, 8, bits per pipeline stage; the width of one ripple-carry slice.
- NUM_SLICES, WIDTH/SLICE (4), derived localparam; number of stages and the latency in cycles. Not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rstN  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  pipeline advance enable; 0 freezes every pipeline register.
- inValid  input  1  a, b and cIn carry a valid operation this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cIn  input  1  carry into bit 0.
- sum  output  WIDTH  registered result a+b+cIn mod 2^WIDTH.
- cOut  output  1  registered carry out of bit WIDTH-1.
- ovf  output  1  registered signed overflow.
- outValid  output  1  sum, cOut and ovf hold a valid result.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rstN=0 at a rising edge):
  - All valid flags clear. sum=0, cOut=0, ovf=0, outValid=0.
  - All skew, carry and partial-sum registers clear.
  - Reset takes priority over en.
  - Reset mid-operation discards every in-flight operation; none emerges after rstN returns high.
- Stage k (k = 0..NUM_SLICES-1):
  - Adds operand slice k (bits k*SLICE+SLICE-1 .. k*SLICE) plus carry-in.
  - Stage 0 carry-in is cIn; stage k>0 carry-in is the carry register written by stage k-1.
  - Each stage registers: its sum byte, its carry-out, a valid bit, the remaining higher operand slices (input skew), and the lower sum bytes already computed (output deskew).
- Stage 0 adds directly from the ports. Higher operand slices are delayed k cycles so each slice meets its carry.
- Latency: with inValid=1 and en=1 in cycle 0, the result appears on sum/cOut/ovf with outValid=1 in cycle NUM_SLICES (4 at defaults), provided en=1 at every intervening edge.
- Throughput: one operation per cycle. Back-to-back operations emerge back-to-back, in order.
- en=0: every register, outputs included, holds its value. The pipeline resumes exactly where it stopped. Input ports are ignored while en=0.
- inValid=0 with en=1: a bubble (valid=0) enters stage 0 and propagates. Data registers may update, but outValid=0 for that slot. sum/cOut/ovf content during outValid=0 is don't-care except after reset (0).
- Arithmetic:
  - {cOut,sum} = a + b + cIn at full WIDTH+1 precision.
  - ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), computed in the last stage from the delayed operand MSBs.
  - No saturation; wrap-around is modulo 2^WIDTH.
- Carry chain: the full-ripple path is confined to one SLICE-bit slice per cycle; no combinational path crosses a stage register.
- No ready/backpressure output. The upstream producer must honour en itself.

Test Plan:
- Carry across all slices: a=32'hFFFFFFFF, b=0, cIn=1, inValid=1 in cycle 0, en=1 → cycle 4: sum=0, cOut=1, ovf=0, outValid=1. outValid=0 in cycles 1-3.
- Signed overflow: a=32'h7FFFFFFF, b=1, cIn=0 → sum=32'h80000000, cOut=0, ovf=1. Also a=32'h80000000, b=32'h80000000 → sum=0, cOut=1, ovf=1.
- Streaming: 100 consecutive random (a,b,cIn) with inValid=1 → 100 consecutive outValid=1 results, in order, each matching a+b+cIn, first result in cycle 4.
- Stall: issue ops X (cycle 0) and Y (cycle 1), drop en for cycles 2-4, then raise it → X appears 3 cycles later than nominal and Y the cycle after. Outputs and outValid are unchanged while en=0.
- Bubbles: alternate inValid 1/0 for 10 cycles → outValid shows the same 1/0 pattern delayed 4 cycles, with correct sums in valid slots.
- Reset mid-flight: issue 3 ops, assert rstN=0 for one edge in cycle 2, then release → outputs immediately 0/outValid=0. No stale result ever appears. A new op issued after release returns correctly 4 cycles later.
